// File: rtl/vib_pkg.sv
// Shared types for the vibrato scheduler: voice state enum, the per-voice
// stored-state record and a couple of small helpers used by the top level.
package vib_pkg;

    // Width of a voice's vibrato offset (0..2*DEPTH, DEPTH up to 255)
    localparam int VIB_W  = 9;
    // Width of the shared delay/step counter (covers DELAY_LEN up to 65536)
    localparam int CNT_W  = 16;
    // MIDI note number width
    localparam int NOTE_W = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } vib_state_t;

    // Everything stored per voice except the pending-repeat flag, which is
    // written outside visits and therefore lives in its own register.
    typedef struct packed {
        vib_state_t              st;
        logic [NOTE_W-1:0]       note_reg;
        logic [CNT_W-1:0]        cnt;
        logic                    dir;      // 0 = counting up
        logic [VIB_W-1:0]        val;
    } voice_t;

    // Idle voice parked at the centre of the swing
    function automatic voice_t voice_idle(input logic [VIB_W-1:0] centre,
                                          input logic [NOTE_W-1:0] keep_note);
        voice_t v;
        v.st       = IDLE;
        v.note_reg = keep_note;
        v.cnt      = '0;
        v.dir      = 1'b0;
        v.val      = centre;
        return v;
    endfunction

    function automatic logic is_run(input voice_t v);
        return (v.st == RUN);
    endfunction

endpackage

// File: rtl/vib_voice_next.sv
// Combinational next-state for one voice visit. A single instance is shared
// by every slot; the top level muxes the visited voice in and writes back.
module vib_voice_next
    import vib_pkg::*;
#(
    parameter int DEPTH     = 15,
    parameter int DELAY_LEN = 4096,
    parameter int STEP_LEN  = 32
) (
    input  voice_t            cur,
    input  logic              note_on,
    input  logic              rep,
    input  logic [NOTE_W-1:0] note,
    input  logic [1:0]        wheel,
    output voice_t            nxt
);

    localparam logic [VIB_W-1:0] CENTRE     = VIB_W'(DEPTH);
    localparam logic [VIB_W-1:0] TOP        = VIB_W'(2 * DEPTH);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_LEN - 1);
    localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_LEN - 1);

    logic [VIB_W-1:0] step_val;
    logic             step_dir;
    logic             restart;

    // One triangle step; the extremes bounce straight back without dwelling
    always_comb begin
        step_val = cur.val;
        step_dir = cur.dir;
        if (!cur.dir) begin
            if (cur.val < TOP) begin
                step_val = cur.val + VIB_W'(1);
            end else begin
                step_dir = 1'b1;
                step_val = TOP - VIB_W'(1);
            end
        end else begin
            if (cur.val > '0) begin
                step_val = cur.val - VIB_W'(1);
            end else begin
                step_dir = 1'b0;
                step_val = VIB_W'(1);
            end
        end
    end

    // A new note, a retrigger, or a first visit all start the delay afresh
    assign restart = (cur.st == IDLE) || (note != cur.note_reg) || rep;

    // Visit rules in priority order: gate off, (re)start, delay, run
    always_comb begin
        nxt = cur;
        if (!note_on) begin
            nxt = voice_idle(CENTRE, cur.note_reg);
        end else if (restart) begin
            nxt.st       = DELAY;
            nxt.note_reg = note;
            nxt.cnt      = '0;
            nxt.val      = CENTRE;
            nxt.dir      = 1'b0;
        end else if (cur.st == DELAY) begin
            if ((cur.cnt == DELAY_LAST) || (wheel != 2'd0)) begin
                nxt.st  = RUN;
                nxt.cnt = '0;
            end else begin
                nxt.cnt = cur.cnt + CNT_W'(1);
            end
        end else begin
            if (cur.cnt == STEP_LAST) begin
                nxt.cnt = '0;
                nxt.val = step_val;
                nxt.dir = step_dir;
            end else begin
                nxt.cnt = cur.cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/vibrato_sched.sv
// Time-multiplexed vibrato scheduler. A round-robin slot pointer visits one
// voice per enabled clock; the shared next-state block updates that voice.
module vibrato_sched
    import vib_pkg::*;
#(
    parameter int VOICES    = 4,
    parameter int DEPTH     = 15,
    parameter int DELAY_LEN = 4096,
    parameter int STEP_LEN  = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    en,
    input  logic [VOICES-1:0]       note_on,
    input  logic [VOICES-1:0]       note_repeat,
    input  logic [7*VOICES-1:0]     note,
    input  logic [2*VOICES-1:0]     wheel,
    output logic [VIB_W*VOICES-1:0] vib_out,
    output logic [VOICES-1:0]       vib_active,
    output logic [3:0]              slot
);

    localparam logic [VIB_W-1:0] CENTRE    = VIB_W'(DEPTH);
    localparam logic [3:0]       SLOT_LAST = 4'(VOICES - 1);

    logic [1:0]        rst_sync_reg;
    logic              rst_int_n;

    logic [3:0]        slot_reg;
    logic [3:0]        slot_next;
    logic [VOICES-1:0] visit_hit;

    voice_t            voice_reg [VOICES];
    logic [VOICES-1:0] rep_pend_reg;
    logic [VIB_W-1:0]  vib_out_reg [VOICES];
    logic [VOICES-1:0] vib_active_reg;

    voice_t            sel_cur;
    voice_t            sel_next;
    logic              sel_on;
    logic              sel_rep;
    logic [NOTE_W-1:0] sel_note;
    logic [1:0]        sel_wheel;

    // Reset asserts immediately but is released on a clock edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_reg[1];

    assign slot_next = (slot_reg == SLOT_LAST) ? 4'd0 : (slot_reg + 4'd1);

    // Round-robin slot pointer, frozen while the scheduler is disabled
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            slot_reg <= 4'd0;
        end else if (en) begin
            slot_reg <= slot_next;
        end
    end

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_hit
            assign visit_hit[gi] = en && (slot_reg == 4'(gi));
        end
    endgenerate

    // Gather the visited voice's stored state and inputs for the shared datapath
    always_comb begin
        sel_cur   = voice_reg[0];
        sel_on    = note_on[0];
        sel_rep   = rep_pend_reg[0] | note_repeat[0];
        sel_note  = note[NOTE_W-1:0];
        sel_wheel = wheel[1:0];
        for (int v = 1; v < VOICES; v++) begin
            if (slot_reg == 4'(v)) begin
                sel_cur   = voice_reg[v];
                sel_on    = note_on[v];
                sel_rep   = rep_pend_reg[v] | note_repeat[v];
                sel_note  = note[7*v +: 7];
                sel_wheel = wheel[2*v +: 2];
            end
        end
    end

    vib_voice_next #(
        .DEPTH     (DEPTH),
        .DELAY_LEN (DELAY_LEN),
        .STEP_LEN  (STEP_LEN)
    ) u_next (
        .cur     (sel_cur),
        .note_on (sel_on),
        .rep     (sel_rep),
        .note    (sel_note),
        .wheel   (sel_wheel),
        .nxt     (sel_next)
    );

    // Write the visited voice back and refresh its output registers
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int v = 0; v < VOICES; v++) begin
                voice_reg[v]   <= voice_idle(CENTRE, '0);
                vib_out_reg[v] <= CENTRE;
            end
            vib_active_reg <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (visit_hit[v]) begin
                    voice_reg[v]      <= sel_next;
                    vib_out_reg[v]    <= sel_next.val;
                    vib_active_reg[v] <= is_run(sel_next);
                end
            end
        end
    end

    // Retrigger pulses are remembered until the voice's next visit consumes them
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            rep_pend_reg <= '0;
        end else begin
            for (int v = 0; v < VOICES; v++) begin
                if (visit_hit[v]) begin
                    rep_pend_reg[v] <= 1'b0;
                end else if (note_repeat[v]) begin
                    rep_pend_reg[v] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < VOICES; gi++) begin : g_out
            assign vib_out[gi*VIB_W +: VIB_W] = vib_out_reg[gi];
        end
    endgenerate

    assign vib_active = vib_active_reg;
    assign slot       = slot_reg;

endmodule

// File: tb/tb_vibrato_sched.sv
// Bench for vibrato_sched: a behavioural model predicts outputs each cycle
// into a scoreboard queue, plus a vector table and directed corner sequences.
module tb_vibrato_sched;

    localparam int V  = 4;
    localparam int D  = 15;
    localparam int DL = 8;
    localparam int SL = 2;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           en = 1'b0;
    logic [V-1:0]   note_on = '0;
    logic [V-1:0]   note_repeat = '0;
    logic [7*V-1:0] note = '0;
    logic [2*V-1:0] wheel = '0;
    logic [9*V-1:0] vib_out;
    logic [V-1:0]   vib_active;
    logic [3:0]     slot;

    vibrato_sched #(
        .VOICES    (V),
        .DEPTH     (D),
        .DELAY_LEN (DL),
        .STEP_LEN  (SL)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .note_on     (note_on),
        .note_repeat (note_repeat),
        .note        (note),
        .wheel       (wheel),
        .vib_out     (vib_out),
        .vib_active  (vib_active),
        .slot        (slot)
    );

    initial forever #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired (t=%0t)", name, $time);
    endtask

    // ---------------- behavioural model + scoreboard ----------------
    typedef struct packed {
        logic [3:0]     slot;
        logic [V-1:0]   act;
        logic [9*V-1:0] vo;
    } exp_t;

    exp_t exp_q[$];

    int m_st[V];     // 0 idle, 1 delay, 2 run
    int m_note[V];
    int m_cnt[V];
    int m_dir[V];
    int m_val[V];
    bit m_pend[V];
    int m_slot;
    int m_rst;

    task automatic model_step();
        bit p[V];
        int v;
        int nn;
        int wh;
        bit rep;
        if (!reset_n) begin
            for (int i = 0; i < V; i++) begin
                m_st[i] = 0; m_note[i] = 0; m_cnt[i] = 0;
                m_dir[i] = 0; m_val[i] = D; m_pend[i] = 0;
            end
            m_slot = 0;
            m_rst = 0;
        end else if (m_rst < 2) begin
            m_rst++;
        end else begin
            for (int i = 0; i < V; i++) p[i] = m_pend[i] || note_repeat[i];
            if (en) begin
                v   = m_slot;
                nn  = int'(note[7*v +: 7]);
                wh  = int'(wheel[2*v +: 2]);
                rep = p[v];
                if (!note_on[v]) begin
                    m_st[v] = 0; m_val[v] = D; m_dir[v] = 0; m_cnt[v] = 0;
                end else if (m_st[v] == 0 || nn != m_note[v] || rep) begin
                    m_st[v] = 1; m_note[v] = nn; m_cnt[v] = 0; m_val[v] = D; m_dir[v] = 0;
                end else if (m_st[v] == 1) begin
                    if (m_cnt[v] == DL - 1 || wh != 0) begin
                        m_st[v] = 2; m_cnt[v] = 0;
                    end else begin
                        m_cnt[v]++;
                    end
                end else begin
                    m_cnt[v]++;
                    if (m_cnt[v] == SL) begin
                        m_cnt[v] = 0;
                        if (m_dir[v] == 0) begin
                            if (m_val[v] < 2*D) m_val[v]++;
                            else begin m_dir[v] = 1; m_val[v] = 2*D - 1; end
                        end else begin
                            if (m_val[v] > 0) m_val[v]--;
                            else begin m_dir[v] = 0; m_val[v] = 1; end
                        end
                    end
                end
                p[v] = 1'b0;
                m_slot = (m_slot + 1) % V;
            end
            m_pend = p;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.slot = 4'(m_slot);
        for (int i = 0; i < V; i++) begin
            e.act[i]        = (m_st[i] == 2);
            e.vo[9*i +: 9]  = 9'(m_val[i]);
        end
        return e;
    endfunction

    initial forever begin
        @(posedge clk);
        model_step();
        exp_q.push_back(model_out());
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_slot", 64'(slot), 64'(e.slot));
            chk("sb_active", 64'(vib_active), 64'(e.act));
            chk("sb_vib_out", 64'(vib_out), 64'(e.vo));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_slot(input int v);
        int b;
        b = 0;
        while (slot != 4'(v) && b < 40) begin
            tick();
            b++;
        end
        if (slot != 4'(v)) timeout("wait_slot");
    endtask

    task automatic wait_act(input int v, input logic lvl, input int budget, output int cyc);
        cyc = 0;
        while (vib_active[v] !== lvl && cyc < budget) begin
            tick();
            cyc++;
        end
        if (vib_active[v] !== lvl) begin
            timeout("wait_active");
            cyc = -1;
        end
    endtask

    function automatic int vo_of(input int v);
        return int'(vib_out[9*v +: 9]);
    endfunction

    function automatic int tri_val(input int k);
        int u;
        u = (k + D) % (4*D);
        return (u <= 2*D) ? u : (4*D - u);
    endfunction

    task automatic start_voice(input int v, input int nt, input int wh);
        note[7*v +: 7]  = 7'(nt);
        wheel[2*v +: 2] = 2'(wh);
        note_on[v]      = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int v;
        int nt;
        int wh;
        int lo;   // earliest cycle count to RUN
        int hi;   // latest cycle count to RUN
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int prev;
        int c;

        // Visits to RUN: 1 idle visit + 8 delay visits without wheel, 2 with wheel
        vecs[0] = '{v: 0, nt: 60, wh: 0, lo: 33, hi: 36};
        vecs[1] = '{v: 2, nt: 40, wh: 1, lo: 5,  hi: 8};
        vecs[2] = '{v: 1, nt: 10, wh: 3, lo: 5,  hi: 8};
        vecs[3] = '{v: 3, nt: 72, wh: 2, lo: 5,  hi: 8};

        // Reset state
        repeat (3) tick();
        for (int i = 0; i < V; i++) begin
            chk("rst_vib_out", 64'(vo_of(i)), 64'(D));
        end
        chk("rst_active", 64'(vib_active), 64'(0));
        chk("rst_slot", 64'(slot), 64'(0));
        reset_n = 1'b1;
        en      = 1'b1;
        repeat (6) tick();

        // Table-driven start-up latencies
        for (int i = 0; i < 4; i++) begin
            start_voice(vecs[i].v, vecs[i].nt, vecs[i].wh);
            wait_act(vecs[i].v, 1'b1, 60, cyc);
            n_cmp++;
            if (cyc < vecs[i].lo || cyc > vecs[i].hi) begin
                n_bad++;
                $display("FAIL vec_latency[%0d]: got %0d cycles, expected %0d..%0d",
                         i, cyc, vecs[i].lo, vecs[i].hi);
            end
            chk("vec_run_val", 64'(vo_of(vecs[i].v)), 64'(D));
            note_on[vecs[i].v] = 1'b0;
            wheel              = '0;
            repeat (8) tick();
            chk("vec_stop_act", 64'(vib_active[vecs[i].v]), 64'(0));
            chk("vec_stop_val", 64'(vo_of(vecs[i].v)), 64'(D));
        end

        // Basic vibrato on voice 0: triangle shape and 8-cycle step period
        start_voice(0, 60, 0);
        wait_act(0, 1'b1, 60, cyc);
        for (int k = 1; k <= 70; k++) begin
            prev = vo_of(0);
            c = 0;
            while (vo_of(0) == prev && c < 20) begin
                tick();
                c++;
            end
            chk("lfo_val", 64'(vo_of(0)), 64'(tri_val(k)));
            chk("lfo_period", 64'(c), 64'(8));
        end

        // Repeat pulse two cycles ahead of voice 1's slot restarts only voice 1
        start_voice(1, 50, 1);
        wait_act(1, 1'b1, 60, cyc);
        wheel[3:2] = 2'd0;
        wait_slot(3);
        note_repeat[1] = 1'b1;
        tick();
        note_repeat[1] = 1'b0;
        wait_slot(1);
        tick();
        chk("rep_val", 64'(vo_of(1)), 64'(D));
        chk("rep_active", 64'(vib_active[1]), 64'(0));
        chk("rep_other", 64'(vib_active[0]), 64'(1));
        wait_act(1, 1'b1, 60, cyc);
        chk("rep_delay", 64'(cyc), 64'(32));

        // Note change in RUN restarts voice 3; stop wins over a pending repeat
        start_voice(3, 60, 1);
        wait_act(3, 1'b1, 60, cyc);
        note[21 +: 7] = 7'd62;
        wait_slot(3);
        tick();
        chk("chg_val", 64'(vo_of(3)), 64'(D));
        chk("chg_active", 64'(vib_active[3]), 64'(0));
        wait_act(3, 1'b1, 20, cyc);
        chk("chg_rerun", 64'(cyc), 64'(4));
        wait_slot(0);
        note_repeat[3] = 1'b1;
        note_on[3]     = 1'b0;
        tick();
        note_repeat[3] = 1'b0;
        wait_slot(3);
        tick();
        chk("stop_val", 64'(vo_of(3)), 64'(D));
        chk("stop_active", 64'(vib_active[3]), 64'(0));

        // Enable hold with a repeat pulse that lands on the first visit after
        start_voice(2, 30, 1);
        wait_act(2, 1'b1, 60, cyc);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) note_repeat[2] = 1'b1;
            if (i == 6) note_repeat[2] = 1'b0;
            tick();
            chk("hold_active", 64'(vib_active[2]), 64'(1));
        end
        wheel[5:4] = 2'd0;
        en = 1'b1;
        wait_slot(2);
        tick();
        chk("hold_rep_val", 64'(vo_of(2)), 64'(D));
        chk("hold_rep_active", 64'(vib_active[2]), 64'(0));

        // Reset asserted mid-RUN
        repeat (3) tick();
        chk("pre_reset_run", 64'(vib_active[0]), 64'(1));
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < V; i++) begin
            chk("mid_rst_vib_out", 64'(vo_of(i)), 64'(D));
        end
        chk("mid_rst_active", 64'(vib_active), 64'(0));
        chk("mid_rst_slot", 64'(slot), 64'(0));
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vibrato_sched.md
# vibrato_sched

Time-multiplexed vibrato scheduler: one shared triangle-LFO update datapath serves `VOICES` MIDI voices. A round-robin slot pointer visits one voice per enabled clock. On each visit the block applies note start/restart/stop events and delay/step timing to that voice's stored state. It sits between the per-channel note decoders and the pitch/frequency lookup, and supplies each voice a 9-bit offset centred on `DEPTH`.

## Interface
- `VOICES`, 4: number of voices; 2..16.
- `DEPTH`, 15: half-swing; centre value; 1..255.
- `DELAY_LEN`, 4096: visits spent in DELAY before vibrato starts.
- `STEP_LEN`, 32: visits per ±1 LFO step in RUN.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `en` in 1: scheduler enable.
- `note_on` in VOICES: per-voice gate.
- `note_repeat` in VOICES: per-voice retrigger pulse; may be 1 cycle wide.
- `note` in 7*VOICES: per-voice note number; voice v is bits [7v+6:7v].
- `wheel` in 2*VOICES: per-voice mod wheel; nonzero skips the delay.
- `vib_out` out 9*VOICES: per-voice offset, 0..2*DEPTH.
- `vib_active` out VOICES: voice is in RUN.
- `slot` out 4: voice visited this cycle.

## Operation
- Per-voice stored state: `st` ∈ {IDLE, DELAY, RUN}, `note_reg`[6:0], `cnt` (delay or step counter), `dir` (0=up), `val`[8:0], `rep_pend`.
- `rep_pend[v]` is set on any cycle where `note_repeat[v]`=1. It is cleared when voice v is visited. Visit logic sees `rep = rep_pend[v] | note_repeat[v]`, so a pulse that coincides with the visit is still consumed.
- Visit rules, in priority order:
  - `note_on[v]`=0: st←IDLE, val←DEPTH, dir←0, cnt←0. Pending repeat is discarded.
  - st=IDLE and note_on=1: st←DELAY, note_reg←note, cnt←0, val←DEPTH, dir←0.
  - st≠IDLE and (note≠note_reg or rep): restart exactly as from IDLE. A simultaneous change and repeat gives a single restart.
  - DELAY: if cnt=DELAY_LEN-1 or wheel≠0, st←RUN and cnt←0; else cnt←cnt+1.
  - RUN: if cnt=STEP_LEN-1, cnt←0 and step the LFO; else cnt←cnt+1.
- LFO step:
  - Going up: if val<2*DEPTH, val+1; else dir←1 and val←2*DEPTH-1.
  - Going down: if val>0, val-1; else dir←0 and val←1.
  - The result is a symmetric triangle with no dwell at the extremes.
- `en`=0: slot pointer holds. Stored state is frozen, `rep_pend` keeps capturing, and outputs hold their values.
- `vib_out[v]` = registered `val` of v. `vib_active[v]` = (st=RUN).

## Timing
- Reset (async assert, sync-released internally): slot=0, every st=IDLE, val=DEPTH, dir=0, cnt=0, note_reg=0, rep_pend=0.
- Reset output values: `vib_out` = DEPTH for all voices, `vib_active` = 0.
- Slot advances 0,1,…,VOICES-1,0 on each `en` cycle.
- A visit in cycle t updates state at the edge ending t. `vib_out` and `vib_active` change in cycle t+1.
- Event latency, from input change to the state update: at most VOICES cycles.
- Delay duration: DELAY_LEN visits = DELAY_LEN·VOICES cycles.
- Step period: STEP_LEN·VOICES cycles.
- Full LFO cycle: 4·DEPTH steps.
- `wheel` is sampled only during visits.
- `note_on` high and low within one visit interval is not seen; this is accepted.
- Reset asserted mid-operation returns all state to reset values immediately.

## Structure
- Package `vib_pkg` holds:
  - `vib_state_t` enum {IDLE, DELAY, RUN};
  - `VIB_W`=9;
  - a voice-state struct type.
- One combinational sub-module, `vib_voice_next`, computes next voice state from current state plus the slot's inputs. It is instantiated once and shared by all slots.
- The top level holds the slot counter, the state array, the pending flags and the output registers.

## Test plan
All scenarios use VOICES=4, DEPTH=15, DELAY_LEN=8, STEP_LEN=2.
- **Reset:** every vib_out=15, vib_active=0, slot=0. Asserting reset_n low mid-RUN returns these values on the next cycle.
- **Basic vibrato:** voice 0 note_on=1, note=60. vib_active[0] rises after 8 visits (≤36 cycles). vib_out[0] steps 16,17,…,30,29,…,0,1 with one step per 8 cycles.
- **Wheel skip:** voice 2 with wheel=1 enters RUN on its second visit, without waiting out the delay.
- **Repeat pulse:** a 1-cycle note_repeat[1] pulse arriving 2 cycles before voice 1's slot restarts voice 1: val=15, vib_active=0, delay restarts. Other voices are unaffected.
- **Note change and stop:** voice 3 note 60→62 in RUN gives a restart. note_on[3]=0 gives vib_out[3]=15 and vib_active[3]=0 after the next visit, even if a repeat is pending.
- **Enable hold:** en=0 for 20 cycles freezes slot and all outputs. A repeat pulse during the hold is applied on the first visit after en=1.
